// File: rtl/axi_dec_pkg.sv
// Shared types and constants for the AXI address decoders.
package axi_dec_pkg;

  typedef logic [1:0] ar_state_t;

  localparam ar_state_t ST_OPERATIVE = 2'd0;
  localparam ar_state_t ST_DRAIN     = 2'd1;
  localparam ar_state_t ST_ERR_RESP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Index width that stays legal for a single port
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_region_match.sv
// Address-to-port region matcher with lowest-index priority (shared by AR/AW decoders).
module axi_region_match
  import axi_dec_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned N_INIT_PORT = 8,
  parameter int unsigned N_REGION    = 4,
  localparam int unsigned IDX_W      = idx_width(N_INIT_PORT)
) (
  input  logic [ADDR_WIDTH-1:0]                                addr_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] start_addr_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] end_addr_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                 enable_region_i,
  input  logic [N_INIT_PORT-1:0]                               connectivity_map_i,
  output logic [N_INIT_PORT-1:0]                               match_oh_o,
  output logic [IDX_W-1:0]                                     match_idx_o,
  output logic                                                 match_any_o
);

  logic [N_INIT_PORT-1:0] raw_hit;

  // Inclusive unsigned range compare per port, then pick the lowest hit
  always_comb begin
    raw_hit     = '0;
    match_oh_o  = '0;
    match_idx_o = '0;
    match_any_o = 1'b0;
    for (int p = 0; p < int'(N_INIT_PORT); p++) begin
      for (int r = 0; r < int'(N_REGION); r++) begin
        if (enable_region_i[r][p] &&
            (addr_i >= start_addr_i[r][p]) && (addr_i <= end_addr_i[r][p])) begin
          raw_hit[p] = 1'b1;
        end
      end
    end
    raw_hit = raw_hit & connectivity_map_i;
    for (int p = 0; p < int'(N_INIT_PORT); p++) begin
      if (raw_hit[p] && !match_any_o) begin
        match_oh_o[p] = 1'b1;
        match_idx_o   = IDX_W'(p);
        match_any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_ar_decoder_ordered.sv
// AR channel decoder: single-target ordering, outstanding cap, internal DECERR responder.
module axi_ar_decoder_ordered
  import axi_dec_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned N_INIT_PORT     = 8,
  parameter int unsigned N_REGION        = 4,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 arvalid_i,
  output logic                                                 arready_o,
  input  logic [ADDR_WIDTH-1:0]                                araddr_i,
  input  logic [ID_WIDTH-1:0]                                  arid_i,
  input  logic [LEN_WIDTH-1:0]                                 arlen_i,
  output logic [N_INIT_PORT-1:0]                               arvalid_o,
  input  logic [N_INIT_PORT-1:0]                               arready_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                 enable_region_i,
  input  logic [N_INIT_PORT-1:0]                               connectivity_map_i,
  input  logic                                                 rsp_done_i,
  output logic                                                 err_rvalid_o,
  input  logic                                                 err_rready_i,
  output logic [ID_WIDTH-1:0]                                  err_rid_o,
  output logic [1:0]                                           err_rresp_o,
  output logic                                                 err_rlast_o,
  output logic [CNT_W-1:0]                                     outstanding_o
);

  localparam int unsigned IDX_W = idx_width(N_INIT_PORT);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  ar_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     tgt_q, tgt_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;

  logic [N_INIT_PORT-1:0] match_oh;
  logic [IDX_W-1:0]       match_idx;
  logic                   match_any;
  logic                   allow;
  logic                   fwd_hs;
  logic                   dec;

  axi_region_match #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .N_INIT_PORT (N_INIT_PORT),
    .N_REGION    (N_REGION)
  ) u_match (
    .addr_i             (araddr_i),
    .start_addr_i       (START_ADDR_i),
    .end_addr_i         (END_ADDR_i),
    .enable_region_i    (enable_region_i),
    .connectivity_map_i (connectivity_map_i),
    .match_oh_o         (match_oh),
    .match_idx_o        (match_idx),
    .match_any_o        (match_any)
  );

  assign err_rid_o     = id_q;
  assign outstanding_o = cnt_q;

  // Next-state and combinational outputs; new targets only once the previous one drains
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    beat_d       = beat_q;
    len_d        = len_q;
    id_d         = id_q;
    arvalid_o    = '0;
    arready_o    = 1'b0;
    err_rvalid_o = 1'b0;
    err_rlast_o  = 1'b0;
    err_rresp_o  = RESP_OKAY;
    fwd_hs       = 1'b0;
    allow        = (cnt_q == '0) || ((match_idx == tgt_q) && (cnt_q < MAX_CNT));

    case (state_q)
      ST_OPERATIVE: begin
        if (arvalid_i) begin
          if (match_any) begin
            if (allow) begin
              arvalid_o = match_oh;
              arready_o = |(arready_i & match_oh);
              fwd_hs    = arready_o;
            end
          end else begin
            arready_o = 1'b1;
            id_d      = arid_i;
            len_d     = arlen_i;
            beat_d    = '0;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_ERR_RESP;
      end
      ST_ERR_RESP: begin
        err_rvalid_o = 1'b1;
        err_rresp_o  = RESP_DECERR;
        err_rlast_o  = (beat_q == len_q);
        if (err_rready_i) begin
          if (err_rlast_o) begin
            beat_d  = '0;
            state_d = ST_OPERATIVE;
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_OPERATIVE;
    endcase

    if (fwd_hs) tgt_d = match_idx;

    dec   = rsp_done_i && (cnt_q != '0);
    cnt_d = cnt_q;
    if (fwd_hs && !dec)      cnt_d = cnt_q + CNT_W'(1);
    else if (dec && !fwd_hs) cnt_d = cnt_q - CNT_W'(1);
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OPERATIVE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_axi_ar_decoder_ordered.sv
// Directed bench for axi_ar_decoder_ordered: decode table plus ordering/error sequences.
module tb_axi_ar_decoder_ordered;

  localparam int unsigned AW = 32;
  localparam int unsigned NP = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 4;
  localparam int unsigned LW = 8;
  localparam int unsigned MO = 2;
  localparam int unsigned CW = $clog2(MO + 1);

  logic                          clk;
  logic                          rst_n;
  logic                          arvalid_i;
  logic                          arready_o;
  logic [AW-1:0]                 araddr_i;
  logic [IW-1:0]                 arid_i;
  logic [LW-1:0]                 arlen_i;
  logic [NP-1:0]                 arvalid_o;
  logic [NP-1:0]                 arready_i;
  logic [NR-1:0][NP-1:0][AW-1:0] start_a;
  logic [NR-1:0][NP-1:0][AW-1:0] end_a;
  logic [NR-1:0][NP-1:0]         en;
  logic [NP-1:0]                 conn;
  logic                          rsp_done_i;
  logic                          err_rvalid_o;
  logic                          err_rready_i;
  logic [IW-1:0]                 err_rid_o;
  logic [1:0]                    err_rresp_o;
  logic                          err_rlast_o;
  logic [CW-1:0]                 outstanding_o;

  int n_vec  = 0;
  int n_miss = 0;

  axi_ar_decoder_ordered #(
    .ADDR_WIDTH(AW), .N_INIT_PORT(NP), .N_REGION(NR),
    .ID_WIDTH(IW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i),
    .arid_i(arid_i), .arlen_i(arlen_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .START_ADDR_i(start_a), .END_ADDR_i(end_a), .enable_region_i(en),
    .connectivity_map_i(conn), .rsp_done_i(rsp_done_i),
    .err_rvalid_o(err_rvalid_o), .err_rready_i(err_rready_i),
    .err_rid_o(err_rid_o), .err_rresp_o(err_rresp_o), .err_rlast_o(err_rlast_o),
    .outstanding_o(outstanding_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        vld;
    logic [7:0]  rdy;
    logic [7:0]  exp_avo;
    logic        exp_aro;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic [31:0] a, input logic v, input logic [7:0] r);
    araddr_i  = a;
    arvalid_i = v;
    arready_i = r;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   beats;
    int   guard;
    logic rr;

    // Region map
    start_a = '0; end_a = '0; en = '0;
    start_a[0][2] = 32'h1000; end_a[0][2] = 32'h1FFF; en[0][2] = 1'b1;
    start_a[0][1] = 32'h2000; end_a[0][1] = 32'h2FFF; en[0][1] = 1'b1;
    start_a[1][3] = 32'h2000; end_a[1][3] = 32'h3FFF; en[1][3] = 1'b1;
    start_a[0][4] = 32'h4000; end_a[0][4] = 32'h4FFF; en[0][4] = 1'b1;
    start_a[2][5] = 32'h5000; end_a[2][5] = 32'h5FFF; en[2][5] = 1'b1;
    start_a[3][6] = 32'h6000; end_a[3][6] = 32'h6FFF; en[3][6] = 1'b0;
    start_a[0][7] = 32'h0000; end_a[0][7] = 32'h0FFF; en[0][7] = 1'b1;
    start_a[0][0] = 32'h8000; end_a[0][0] = 32'h8FFF; en[0][0] = 1'b1;
    conn = 8'b1101_1111;

    tbl[0] = '{32'h1000, 1'b1, 8'hFB, 8'h04, 1'b0};
    tbl[1] = '{32'h1FFF, 1'b1, 8'hFB, 8'h04, 1'b0};
    tbl[2] = '{32'h0FFF, 1'b1, 8'h7F, 8'h80, 1'b0};
    tbl[3] = '{32'h2000, 1'b1, 8'hFD, 8'h02, 1'b0};
    tbl[4] = '{32'h2FFF, 1'b1, 8'hFD, 8'h02, 1'b0};
    tbl[5] = '{32'h3000, 1'b1, 8'hF7, 8'h08, 1'b0};
    tbl[6] = '{32'h3FFF, 1'b1, 8'hF7, 8'h08, 1'b0};
    tbl[7] = '{32'h4000, 1'b1, 8'hEF, 8'h10, 1'b0};
    tbl[8] = '{32'h8FFF, 1'b1, 8'hFE, 8'h01, 1'b0};
    tbl[9] = '{32'h1000, 1'b0, 8'hFF, 8'h00, 1'b0};

    rst_n = 1'b0; drv(32'h0, 1'b0, 8'h00);
    arid_i = '0; arlen_i = '0; rsp_done_i = 1'b0; err_rready_i = 1'b0;
    #1;
    chk("reset_outputs",
        32'({arvalid_o, arready_o, err_rvalid_o, err_rlast_o, err_rresp_o, outstanding_o}), 32'h0);
    chk("reset_rid", 32'(err_rid_o), 32'h0);
    nxt(); nxt();
    rst_n = 1'b1;

    // Decode table: no handshake ever completes, so state stays idle
    for (int i = 0; i < 10; i++) begin
      nxt();
      drv(tbl[i].addr, tbl[i].vld, tbl[i].rdy);
      #1;
      chk($sformatf("table_%0d", i),
          32'({arvalid_o, arready_o, err_rvalid_o, outstanding_o}),
          32'({tbl[i].exp_avo, tbl[i].exp_aro, 1'b0, 2'd0}));
    end

    // Same-cycle forward to port 2 at the top of its range
    nxt(); drv(32'h1FFF, 1'b1, 8'h04); #1;
    chk("fwd_top_avo", 32'(arvalid_o), 32'h04);
    chk("fwd_top_aro", 32'(arready_o), 32'h1);
    nxt(); drv(32'h0, 1'b0, 8'h00); rsp_done_i = 1'b1; #1;
    chk("fwd_top_outst", 32'(outstanding_o), 32'd1);
    nxt(); rsp_done_i = 1'b0; #1;
    chk("fwd_top_drained", 32'(outstanding_o), 32'd0);

    // Outstanding cap of 2 on port 0
    nxt(); drv(32'h8000, 1'b1, 8'h01); #1;
    chk("cap_req1", 32'({arvalid_o, arready_o}), 32'({8'h01, 1'b1}));
    nxt(); #1;
    chk("cap_req2", 32'({arvalid_o, arready_o}), 32'({8'h01, 1'b1}));
    nxt(); #1;
    chk("cap_req3_stall", 32'({arvalid_o, arready_o, outstanding_o}), 32'({8'h00, 1'b0, 2'd2}));
    nxt(); rsp_done_i = 1'b1; #1;
    chk("cap_req3_stall_done", 32'({arvalid_o, arready_o}), 32'({8'h00, 1'b0}));
    nxt(); rsp_done_i = 1'b0; #1;
    chk("cap_req3_fwd", 32'({arvalid_o, arready_o, outstanding_o}), 32'({8'h01, 1'b1, 2'd1}));
    nxt(); drv(32'h0, 1'b0, 8'h00); rsp_done_i = 1'b1; #1;
    chk("cap_outst2", 32'(outstanding_o), 32'd2);
    nxt(); #1;
    chk("cap_outst1", 32'(outstanding_o), 32'd1);
    nxt(); #1;
    chk("cap_outst0", 32'(outstanding_o), 32'd0);
    nxt(); rsp_done_i = 1'b0; #1;
    chk("cap_no_underflow", 32'(outstanding_o), 32'd0);

    // Different target must wait for full drain
    nxt(); drv(32'h2000, 1'b1, 8'h02); #1;
    chk("ord_p1_a", 32'({arvalid_o, arready_o}), 32'({8'h02, 1'b1}));
    nxt(); #1;
    chk("ord_p1_b", 32'({arvalid_o, arready_o}), 32'({8'h02, 1'b1}));
    nxt(); drv(32'h4000, 1'b1, 8'h10); #1;
    chk("ord_p4_stall", 32'({arvalid_o, arready_o, outstanding_o}), 32'({8'h00, 1'b0, 2'd2}));
    nxt(); rsp_done_i = 1'b1; #1;
    chk("ord_p4_stall2", 32'({arvalid_o, arready_o}), 32'({8'h00, 1'b0}));
    nxt(); #1;
    chk("ord_p4_stall1", 32'({arvalid_o, arready_o, outstanding_o}), 32'({8'h00, 1'b0, 2'd1}));
    nxt(); rsp_done_i = 1'b0; #1;
    chk("ord_p4_fwd", 32'({arvalid_o, arready_o, outstanding_o}), 32'({8'h10, 1'b1, 2'd0}));
    nxt(); drv(32'h0, 1'b0, 8'h00); rsp_done_i = 1'b1; #1;
    chk("ord_outst1", 32'(outstanding_o), 32'd1);
    nxt(); rsp_done_i = 1'b0; #1;
    chk("ord_outst0", 32'(outstanding_o), 32'd0);

    // Unmapped (connectivity-masked) read with one outstanding, ID 5, 4 beats
    nxt(); drv(32'h1000, 1'b1, 8'h04); #1;
    chk("err_pre_fwd", 32'(arready_o), 32'h1);
    nxt(); drv(32'h5000, 1'b1, 8'hFF); arid_i = 4'd5; arlen_i = 8'd3; #1;
    chk("err_accept", 32'({arvalid_o, arready_o, err_rvalid_o}), 32'({8'h00, 1'b1, 1'b0}));
    nxt(); drv(32'h1000, 1'b1, 8'h04); arid_i = 4'd0; arlen_i = 8'd0; #1;
    chk("drain_stall", 32'({arvalid_o, arready_o, err_rvalid_o}), 32'h0);
    nxt(); drv(32'h0, 1'b0, 8'h00); #1;
    chk("drain_wait", 32'(err_rvalid_o), 32'h0);
    nxt(); rsp_done_i = 1'b1; #1;
    chk("drain_done_cyc", 32'(err_rvalid_o), 32'h0);
    nxt(); rsp_done_i = 1'b0; #1;
    chk("drain_cnt0", 32'({err_rvalid_o, outstanding_o}), 32'h0);
    nxt(); drv(32'h1000, 1'b1, 8'h04); err_rready_i = 1'b0; #1;
    chk("err_first", 32'({err_rvalid_o, err_rid_o, err_rresp_o, err_rlast_o}),
        32'({1'b1, 4'd5, 2'b11, 1'b0}));
    chk("err_ar_block", 32'({arvalid_o, arready_o}), 32'h0);
    drv(32'h0, 1'b0, 8'h00);
    beats = 0; guard = 0; rr = 1'b0;
    while (beats < 4 && guard < 40) begin
      nxt(); rr = ~rr; err_rready_i = rr; #1;
      chk("err_hold", 32'(err_rvalid_o), 32'h1);
      if (err_rvalid_o && rr) begin
        chk("beat_fields", 32'({err_rid_o, err_rresp_o}), 32'({4'd5, 2'b11}));
        chk($sformatf("beat%0d_last", beats), 32'(err_rlast_o), 32'(beats == 3));
        beats++;
      end
      guard++;
    end
    chk("err_beat_count", 32'(beats), 32'd4);
    nxt(); err_rready_i = 1'b0; #1;
    chk("err_done", 32'(err_rvalid_o), 32'h0);

    // Single-beat error for arlen 0 (disabled region)
    nxt(); drv(32'h6000, 1'b1, 8'hFF); arid_i = 4'hA; arlen_i = 8'd0; #1;
    chk("len0_accept", 32'(arready_o), 32'h1);
    nxt(); drv(32'h0, 1'b0, 8'h00); #1;
    chk("len0_drain", 32'(err_rvalid_o), 32'h0);
    nxt(); err_rready_i = 1'b1; #1;
    chk("len0_beat", 32'({err_rvalid_o, err_rlast_o, err_rid_o}), 32'({1'b1, 1'b1, 4'hA}));
    nxt(); err_rready_i = 1'b0; #1;
    chk("len0_done", 32'(err_rvalid_o), 32'h0);

    // Reset in the middle of an error burst
    nxt(); drv(32'h5000, 1'b1, 8'hFF); arid_i = 4'd9; arlen_i = 8'd3; #1;
    chk("rst_accept", 32'(arready_o), 32'h1);
    nxt(); drv(32'h0, 1'b0, 8'h00); #1;
    nxt(); err_rready_i = 1'b1; #1;
    chk("rst_beat1", 32'({err_rvalid_o, err_rlast_o}), 32'({1'b1, 1'b0}));
    nxt(); #1;
    chk("rst_beat2", 32'({err_rvalid_o, err_rid_o}), 32'({1'b1, 4'd9}));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_burst",
        32'({err_rvalid_o, err_rlast_o, err_rresp_o, err_rid_o, outstanding_o, arready_o}), 32'h0);
    nxt(); rst_n = 1'b1; err_rready_i = 1'b0; #1;
    chk("rst_released", 32'(err_rvalid_o), 32'h0);
    nxt(); drv(32'h1000, 1'b1, 8'h04); #1;
    chk("rst_operative", 32'({arvalid_o, arready_o}), 32'({8'h04, 1'b1}));
    nxt(); drv(32'h0, 1'b0, 8'h00); rsp_done_i = 1'b1; #1;
    chk("rst_outst1", 32'(outstanding_o), 32'd1);
    nxt(); rsp_done_i = 1'b0; #1;
    chk("rst_outst0", 32'(outstanding_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axi_ar_decoder_ordered.md
AXI_AR_DECODER_ORDERED -- requirements
Module: axi_ar_decoder_ordered

Interface
REQ-001 Parameter ADDR_WIDTH, 32, read address width.
REQ-002 Parameter N_INIT_PORT, 8, number of downstream slave ports.
REQ-003 Parameter N_REGION, 4, address regions per slave port.
REQ-004 Parameter ID_WIDTH, 4, AXI ID width.
REQ-005 Parameter LEN_WIDTH, 8, ARLEN width.
REQ-006 Parameter MAX_OUTSTANDING, 8, maximum accepted-but-uncompleted reads (at least 1).
REQ-007 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 is the clock; rst_n input 1 is the reset.
REQ-008 arvalid_i input 1, arready_o output 1, araddr_i input ADDR_WIDTH, arid_i input ID_WIDTH, arlen_i input LEN_WIDTH: upstream AR handshake and fields.
REQ-009 arvalid_o output N_INIT_PORT, arready_i input N_INIT_PORT: per-slave AR handshake.
REQ-010 START_ADDR_i and END_ADDR_i, input [N_REGION][N_INIT_PORT][ADDR_WIDTH]; enable_region_i, input [N_REGION][N_INIT_PORT]: region map.
REQ-011 connectivity_map_i input N_INIT_PORT: reachable slaves.
REQ-012 rsp_done_i input 1: one-cycle pulse per completed slave read burst (RLAST handshake).
REQ-013 err_rvalid_o output 1, err_rready_i input 1, err_rid_o output ID_WIDTH, err_rresp_o output 2, err_rlast_o output 1: internal decode-error R responder.
REQ-014 outstanding_o output clog2(MAX_OUTSTANDING+1): current outstanding count.

Function
REQ-015 Region hit for port p SHALL be the OR over regions r of (enable_region_i[r][p] AND START_ADDR_i[r][p] <= araddr_i <= END_ADDR_i[r][p]), unsigned and inclusive, ANDed with connectivity_map_i[p].
REQ-016 If several ports hit, the lowest-index port SHALL be selected, so arvalid_o is always zero or one-hot.
REQ-017 A request to hit port p SHALL be forwarded (arvalid_o[p]=arvalid_i, arready_o=arready_i[p]) only when cnt==0, or when p equals the registered target tgt and cnt<MAX_OUTSTANDING; otherwise arvalid_o=0 and arready_o=0 (stall).
REQ-018 On a forwarded handshake, tgt SHALL load p and cnt SHALL increment; on rsp_done_i cnt SHALL decrement; on both in one cycle cnt SHALL be unchanged; rsp_done_i at cnt==0 SHALL be ignored.
REQ-019 FSM states: OPERATIVE, DRAIN, ERR_RESP.
REQ-020 In OPERATIVE with arvalid_i and no hit, the block SHALL assert arready_o in that cycle with arvalid_o=0, latch arid_i and arlen_i, and go to DRAIN.
REQ-021 In DRAIN, arready_o=0 and arvalid_o=0; on cnt==0 the FSM SHALL go to ERR_RESP next cycle.
REQ-022 In ERR_RESP, err_rvalid_o=1, err_rid_o=latched ID, err_rresp_o=2'b11 (DECERR); the beat counter SHALL advance on err_rvalid_o AND err_rready_i; err_rlast_o=1 on beat arlen+1; the final handshake SHALL return the FSM to OPERATIVE.
REQ-023 In ERR_RESP, arready_o=0 and arvalid_o=0; arlen=0 SHALL give a single beat with err_rlast_o=1.
REQ-024 Outputs SHALL be combinational from state and inputs, so forwarded-AR latency is zero cycles; error R beats start one cycle after drain completes.

Reset
REQ-025 On rst_n low, the FSM SHALL enter OPERATIVE and cnt, tgt, the beat counter, latched ID and latched LEN SHALL be cleared; arready_o, arvalid_o, err_rvalid_o and err_rlast_o SHALL be 0; err_rresp_o SHALL be 2'b00. Reset mid-burst SHALL abandon any error response.

Structure
REQ-026 Package axi_dec_pkg SHALL hold the FSM state enum and the constants RESP_OKAY=2'b00 and RESP_DECERR=2'b11.
REQ-027 Region matching and lowest-index priority SHALL be a combinational sub-module, axi_region_match, reusable by the AW decoder.

Verification
REQ-028 Port 2 region 0x1000-0x1FFF, araddr 0x1FFF, arready_i[2]=1 -> arvalid_o=0b00000100, same-cycle handshake, outstanding_o=1.
REQ-029 Ports 1 and 3 both map 0x2000, araddr 0x2000 -> arvalid_o=0b00000010 only.
REQ-030 cnt=2 to port 1, new request to port 4 -> stalled; after two rsp_done_i pulses it is forwarded the next cycle.
REQ-031 MAX_OUTSTANDING=2, three back-to-back requests to port 0 -> third stalled until one rsp_done_i arrives.
REQ-032 Unmapped address, arid=5, arlen=3, cnt=1 -> arready_o=1 in the same cycle; no R beats until rsp_done_i; then 4 DECERR beats with ID 5, err_rlast_o=1 on the 4th only, err_rready_i toggled.
REQ-033 rst_n asserted during beat 2 of an error burst -> err_rvalid_o=0 immediately, OPERATIVE, outstanding_o=0.
